lcd1602_rx: RTL

- Receiving end of the 8-bit HD44780/LCD1602 parallel write bus (lcd_rs, lcd_rw, lcd_en, lcd_data) that our display drivers produce.
- Decodes command and data writes and keeps a 16x2 character shadow (32-byte DDRAM image) plus display-control state.
- Used as an on-chip display model for bench checking, and as a frame source for alternate displays on the same bus.

---
 rtl/lcd1602_rx.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd1602_rx.sv
// Receiver for an HD44780/LCD1602 8-bit write bus: decodes command and data
// writes into a 16x2 character shadow plus display-control state.
module lcd1602_rx #(
  parameter logic [7:0]  CLR_CHAR    = 8'h20,
  parameter int unsigned MIN_EN_HIGH = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       busy,
  output logic       wr_strobe,
  output logic [7:0] err_cnt
);

  localparam logic [15:0] MIN_CNT = 16'(MIN_EN_HIGH);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  // Input stage
  logic        in_rs_q, in_rw_q, in_en_q;
  logic [7:0]  in_data_q;
  logic        lat_rs_q, lat_rw_q, lat_rs_d, lat_rw_d;
  logic [7:0]  lat_data_q, lat_data_d;
  logic [15:0] en_cnt_q, en_cnt_d;
  logic        strobe;

  // Control state
  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic [6:0]  ac_q, ac_d;
  logic        inc_q, inc_d;
  logic        cg_mode_q, cg_mode_d;
  logic        disp_on_q, disp_on_d;
  logic        cursor_on_q, cursor_on_d;
  logic        blink_on_q, blink_on_d;
  logic        two_line_q, two_line_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [7:0]  rd_char_q, rd_char_d;

  // Shadow write port
  logic [7:0]  shadow_q [32];
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [7:0]  wr_val;

  // DDRAM address step: row 0 spans 0x00-0x27, row 1 spans 0x40-0x67.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) begin
      case (a)
        7'h27:   r = 7'h40;
        7'h67:   r = 7'h00;
        default: r = a + 7'd1;
      endcase
    end else begin
      case (a)
        7'h40:   r = 7'h27;
        7'h00:   r = 7'h67;
        default: r = a - 7'd1;
      endcase
    end
    return r;
  endfunction

  // A strobe is a falling registered en after a long-enough high phase;
  // the latched bus fields are those of the last en-high cycle.
  always_comb begin
    en_cnt_d   = 16'd0;
    lat_rs_d   = lat_rs_q;
    lat_rw_d   = lat_rw_q;
    lat_data_d = lat_data_q;
    if (in_en_q) begin
      en_cnt_d   = (en_cnt_q == MIN_CNT) ? en_cnt_q : en_cnt_q + 16'd1;
      lat_rs_d   = in_rs_q;
      lat_rw_d   = in_rw_q;
      lat_data_d = in_data_q;
    end
    strobe = !in_en_q && (en_cnt_q == MIN_CNT);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    ac_d        = ac_q;
    inc_d       = inc_q;
    cg_mode_d   = cg_mode_q;
    disp_on_d   = disp_on_q;
    cursor_on_d = cursor_on_q;
    blink_on_d  = blink_on_q;
    two_line_d  = two_line_q;
    err_cnt_d   = err_cnt_q;
    wr_strobe_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = idx_q;
    wr_val      = CLR_CHAR;
    rd_char_d   = shadow_q[rd_addr];

    case (state_q)
      S_CLEAR: begin
        wr_en = 1'b1;
        if (idx_q == 5'd31) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          idx_d   = 5'd0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
        if (strobe && !lat_rw_q && err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end

      S_IDLE: begin
        if (strobe && !lat_rw_q) begin
          if (!lat_rs_q) begin
            casez (lat_data_q)
              8'b1???????: begin
                ac_d      = lat_data_q[6:0];
                cg_mode_d = 1'b0;
              end
              8'b01??????: cg_mode_d = 1'b1;
              8'b001?????: two_line_d = lat_data_q[3];
              8'b0001????: ; // cursor/display shift has no shadow effect
              8'b00001???: begin
                disp_on_d   = lat_data_q[2];
                cursor_on_d = lat_data_q[1];
                blink_on_d  = lat_data_q[0];
              end
              8'b000001??: inc_d = lat_data_q[1];
              8'b0000001?: ac_d = 7'h00;
              8'b00000001: begin
                ac_d    = 7'h00;
                inc_d   = 1'b1;
                state_d = S_CLEAR;
                idx_d   = 5'd0;
                busy_d  = 1'b1;
              end
              default: ;
            endcase
          end else begin
            if (!cg_mode_q) begin
              if (ac_q[6:4] == 3'b000) begin
                wr_en       = 1'b1;
                wr_idx      = {1'b0, ac_q[3:0]};
                wr_val      = lat_data_q;
                wr_strobe_d = 1'b1;
              end else if (ac_q[6:4] == 3'b100) begin
                wr_en       = 1'b1;
                wr_idx      = {1'b1, ac_q[3:0]};
                wr_val      = lat_data_q;
                wr_strobe_d = 1'b1;
              end
            end
            ac_d = ac_step(ac_q, inc_q);
          end
        end
      end

      default: begin
        state_d = S_CLEAR;
        idx_d   = 5'd0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      in_rs_q     <= 1'b0;
      in_rw_q     <= 1'b0;
      in_en_q     <= 1'b0;
      in_data_q   <= 8'h00;
      lat_rs_q    <= 1'b0;
      lat_rw_q    <= 1'b0;
      lat_data_q  <= 8'h00;
      en_cnt_q    <= 16'd0;
      state_q     <= S_CLEAR;
      idx_q       <= 5'd0;
      busy_q      <= 1'b1;
      ac_q        <= 7'h00;
      inc_q       <= 1'b1;
      cg_mode_q   <= 1'b0;
      disp_on_q   <= 1'b0;
      cursor_on_q <= 1'b0;
      blink_on_q  <= 1'b0;
      two_line_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      err_cnt_q   <= 8'h00;
      rd_char_q   <= 8'h00;
    end else begin
      in_rs_q     <= lcd_rs;
      in_rw_q     <= lcd_rw;
      in_en_q     <= lcd_en;
      in_data_q   <= lcd_data;
      lat_rs_q    <= lat_rs_d;
      lat_rw_q    <= lat_rw_d;
      lat_data_q  <= lat_data_d;
      en_cnt_q    <= en_cnt_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      ac_q        <= ac_d;
      inc_q       <= inc_d;
      cg_mode_q   <= cg_mode_d;
      disp_on_q   <= disp_on_d;
      cursor_on_q <= cursor_on_d;
      blink_on_q  <= blink_on_d;
      two_line_q  <= two_line_d;
      wr_strobe_q <= wr_strobe_d;
      err_cnt_q   <= err_cnt_d;
      rd_char_q   <= rd_char_d;
    end
  end

  // Shadow storage carries no reset; the reset-time clear fills it.
  always_ff @(posedge sys_clk) begin
    if (wr_en && !sys_rst) begin
      shadow_q[wr_idx] <= wr_val;
    end
  end

  assign rd_char   = rd_char_q;
  assign ac        = ac_q;
  assign disp_on   = disp_on_q;
  assign cursor_on = cursor_on_q;
  assign blink_on  = blink_on_q;
  assign two_line  = two_line_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign err_cnt   = err_cnt_q;

endmodule
